// File: rtl/vend_txn_sequencer.sv
// ============================================================================
// vend_txn_sequencer : coin credit, buy validation, dispense handshake and
//                      change return for the vending machine tray controller
// Revision : 1.0
// ============================================================================
`default_nettype none

module vend_txn_sequencer #(
    parameter int MONEY_W     = 12,
    parameter int PRICE0      = 25,
    parameter int PRICE1      = 75,
    parameter int PRICE2      = 150,
    parameter int PRICE3      = 200,
    parameter int CREDIT_MAX  = 975,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               quarter,
    input  logic               dollar,
    input  logic [3:0]         select,
    input  logic               buy,
    input  logic               cancel,
    input  logic [3:0]         stock_empty,
    input  logic               disp_ack,
    input  logic               chg_ready,
    output logic               disp_req,
    output logic [3:0]         disp_sel,
    output logic [3:0]         stock_dec,
    output logic               chg_q,
    output logic               chg_d,
    output logic               coin_reject,
    output logic [MONEY_W-1:0] credit,
    output logic               busy,
    output logic               err_valid,
    output logic [2:0]         err_code
);

    localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [MONEY_W:0]   CREDIT_LIMIT = (MONEY_W+1)'(CREDIT_MAX);
    localparam logic [MONEY_W:0]   QUARTER_W    = (MONEY_W+1)'(25);
    localparam logic [MONEY_W:0]   DOLLAR_W     = (MONEY_W+1)'(100);
    localparam logic [MONEY_W-1:0] QUARTER_VAL  = MONEY_W'(25);
    localparam logic [MONEY_W-1:0] DOLLAR_VAL   = MONEY_W'(100);
    localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] ERR_SELECT  = 3'd1;
    localparam logic [2:0] ERR_FUNDS   = 3'd2;
    localparam logic [2:0] ERR_SOLDOUT = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    state_t               state;
    logic                 quarter_prev;
    logic                 dollar_prev;
    logic                 buy_prev;
    logic                 cancel_prev;
    logic [TIMER_W-1:0]   timer;
    logic [MONEY_W-1:0]   price_held;

    logic                 quarter_edge;
    logic                 dollar_edge;
    logic                 buy_edge;
    logic                 cancel_edge;
    logic                 coin_edge;
    logic                 sel_onehot;
    logic [MONEY_W-1:0]   sel_price;
    logic [MONEY_W:0]     credit_plus_q;
    logic [MONEY_W:0]     credit_plus_d;

    assign quarter_edge  = quarter & ~quarter_prev;
    assign dollar_edge   = dollar  & ~dollar_prev;
    assign buy_edge      = buy     & ~buy_prev;
    assign cancel_edge   = cancel  & ~cancel_prev;
    assign coin_edge     = quarter_edge | dollar_edge;
    assign sel_onehot    = (select != 4'b0000) && ((select & (select - 4'd1)) == 4'b0000);
    assign credit_plus_q = {1'b0, credit} + QUARTER_W;
    assign credit_plus_d = {1'b0, credit} + DOLLAR_W;

    always_comb begin
        sel_price = '0;
        case (select)
            4'b0001: sel_price = MONEY_W'(PRICE0);
            4'b0010: sel_price = MONEY_W'(PRICE1);
            4'b0100: sel_price = MONEY_W'(PRICE2);
            4'b1000: sel_price = MONEY_W'(PRICE3);
            default: sel_price = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            quarter_prev <= 1'b1;
            dollar_prev  <= 1'b1;
            buy_prev     <= 1'b1;
            cancel_prev  <= 1'b1;
            timer        <= '0;
            price_held   <= '0;
            credit       <= '0;
            disp_req     <= 1'b0;
            disp_sel     <= 4'b0000;
            stock_dec    <= 4'b0000;
            chg_q        <= 1'b0;
            chg_d        <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
            err_valid    <= 1'b0;
            err_code     <= 3'd0;
        end else begin
            quarter_prev <= quarter;
            dollar_prev  <= dollar;
            buy_prev     <= buy;
            cancel_prev  <= cancel;

            stock_dec    <= 4'b0000;
            chg_q        <= 1'b0;
            chg_d        <= 1'b0;
            coin_reject  <= 1'b0;
            err_valid    <= 1'b0;
            err_code     <= 3'd0;

            // Coins are only credited in IDLE with no cancel pending
            if (state != IDLE || cancel_edge) begin
                coin_reject <= coin_edge;
            end

            case (state)
                IDLE: begin
                    if (cancel_edge) begin
                        state <= CHANGE;
                        busy  <= 1'b1;
                    end else if (dollar_edge) begin
                        if (credit_plus_d > CREDIT_LIMIT) begin
                            coin_reject <= 1'b1;
                        end else begin
                            credit <= credit + DOLLAR_VAL;
                        end
                        if (quarter_edge) begin
                            coin_reject <= 1'b1;
                        end
                    end else if (quarter_edge) begin
                        if (credit_plus_q > CREDIT_LIMIT) begin
                            coin_reject <= 1'b1;
                        end else begin
                            credit <= credit + QUARTER_VAL;
                        end
                    end else if (buy_edge) begin
                        state <= CHECK;
                        busy  <= 1'b1;
                    end
                end

                CHECK: begin
                    if (!sel_onehot) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_SELECT;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else if ((stock_empty & select) != 4'b0000) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_SOLDOUT;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else if (credit < sel_price) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_FUNDS;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        disp_req   <= 1'b1;
                        disp_sel   <= select;
                        price_held <= sel_price;
                        timer      <= '0;
                        state      <= DISPENSE;
                    end
                end

                DISPENSE: begin
                    if (disp_ack) begin
                        credit    <= credit - price_held;
                        stock_dec <= disp_sel;
                        disp_req  <= 1'b0;
                        disp_sel  <= 4'b0000;
                        state     <= CHANGE;
                    end else if (timer == TIMER_LAST) begin
                        // Timeout leaves credit intact so CHANGE refunds it all
                        err_valid <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        disp_req  <= 1'b0;
                        disp_sel  <= 4'b0000;
                        state     <= CHANGE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                CHANGE: begin
                    if (chg_ready) begin
                        if (credit >= DOLLAR_VAL) begin
                            chg_d  <= 1'b1;
                            credit <= credit - DOLLAR_VAL;
                        end else if (credit >= QUARTER_VAL) begin
                            chg_q  <= 1'b1;
                            credit <= credit - QUARTER_VAL;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vend_txn_sequencer.sv
// ============================================================================
// tb_vend_txn_sequencer : directed self-checking bench for vend_txn_sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vend_txn_sequencer;

    logic        clk;
    logic        reset_n;
    logic        quarter;
    logic        dollar;
    logic [3:0]  select;
    logic        buy;
    logic        cancel;
    logic [3:0]  stock_empty;
    logic        disp_ack;
    logic        chg_ready;
    logic        disp_req;
    logic [3:0]  disp_sel;
    logic [3:0]  stock_dec;
    logic        chg_q;
    logic        chg_d;
    logic        coin_reject;
    logic [11:0] credit;
    logic        busy;
    logic        err_valid;
    logic [2:0]  err_code;

    int checks;
    int failures;

    vend_txn_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .quarter     (quarter),
        .dollar      (dollar),
        .select      (select),
        .buy         (buy),
        .cancel      (cancel),
        .stock_empty (stock_empty),
        .disp_ack    (disp_ack),
        .chg_ready   (chg_ready),
        .disp_req    (disp_req),
        .disp_sel    (disp_sel),
        .stock_dec   (stock_dec),
        .chg_q       (chg_q),
        .chg_d       (chg_d),
        .coin_reject (coin_reject),
        .credit      (credit),
        .busy        (busy),
        .err_valid   (err_valid),
        .err_code    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_dollar();
        dollar = 1'b1; tick();
        dollar = 1'b0; tick();
    endtask

    task automatic put_quarter();
        quarter = 1'b1; tick();
        quarter = 1'b0; tick();
    endtask

    // buy edge -> CHECK, then one more edge for the CHECK decision
    task automatic press_buy();
        buy = 1'b1; tick();
        buy = 1'b0; tick();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_busy_clear"}, int'(busy), 0);
        check({tag, "_credit_zero"}, int'(credit), 0);
    endtask

    initial begin
        int n;
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        quarter     = 1'b0;
        dollar      = 1'b0;
        select      = 4'b0000;
        buy         = 1'b0;
        cancel      = 1'b0;
        stock_empty = 4'b0000;
        disp_ack    = 1'b0;
        chg_ready   = 1'b1;
        tick(); tick();
        check("rst_credit", int'(credit), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_disp_req", int'(disp_req), 0);
        check("rst_err_valid", int'(err_valid), 0);
        reset_n = 1'b1;
        tick();

        // 1: 200 credit, buy chips (150), ack after 3 cycles, two quarters back
        put_dollar(); put_dollar();
        check("t1_credit200", int'(credit), 200);
        select = 4'b0100;
        press_buy();
        check("t1_disp_req", int'(disp_req), 1);
        check("t1_disp_sel", int'(disp_sel), 4);
        check("t1_busy", int'(busy), 1);
        tick(); tick();
        check("t1_req_held", int'(disp_req), 1);
        disp_ack = 1'b1; tick();
        disp_ack = 1'b0;
        check("t1_stock_dec", int'(stock_dec), 4);
        check("t1_req_drop", int'(disp_req), 0);
        check("t1_credit50", int'(credit), 50);
        tick();
        check("t1_stock_dec_pulse", int'(stock_dec), 0);
        check("t1_chg_q1", int'(chg_q), 1);
        check("t1_credit25", int'(credit), 25);
        tick();
        check("t1_chg_q2", int'(chg_q), 1);
        check("t1_credit0", int'(credit), 0);
        tick();
        check("t1_busy_fall", int'(busy), 0);

        // 2: 50 credit, chocolate (75) -> insufficient funds
        put_quarter(); put_quarter();
        select = 4'b0010;
        press_buy();
        check("t2_err_valid", int'(err_valid), 1);
        check("t2_err_code", int'(err_code), 2);
        check("t2_no_req", int'(disp_req), 0);
        check("t2_credit", int'(credit), 50);
        tick();
        check("t2_err_pulse", int'(err_valid), 0);

        // 3: sold out, then bad select
        put_dollar(); put_quarter(); put_quarter();
        check("t3_credit200", int'(credit), 200);
        stock_empty = 4'b1000;
        select = 4'b1000;
        press_buy();
        check("t3_err_soldout", int'(err_code), 3);
        check("t3_err_valid", int'(err_valid), 1);
        select = 4'b0011;
        press_buy();
        check("t3_err_select", int'(err_code), 1);
        check("t3_credit_kept", int'(credit), 200);
        stock_empty = 4'b0000;
        cancel = 1'b1; tick();
        cancel = 1'b0;
        drain("t3");

        // 4: ack never arrives -> timeout after 1000 cycles, full refund
        put_dollar(); put_quarter();
        select = 4'b0001;
        press_buy();
        check("t4_disp_req", int'(disp_req), 1);
        n = 0;
        while (!err_valid && n < 1100) begin
            tick();
            n++;
        end
        check("t4_timeout_cycles", n, 1000);
        check("t4_err_code", int'(err_code), 4);
        check("t4_req_drop", int'(disp_req), 0);
        check("t4_credit_kept", int'(credit), 125);
        tick();
        check("t4_chg_d", int'(chg_d), 1);
        tick();
        check("t4_chg_q", int'(chg_q), 1);
        check("t4_credit0", int'(credit), 0);
        tick();
        check("t4_busy", int'(busy), 0);

        // 5: cancel with chg_ready 1,0,1 and a coin during CHANGE
        put_dollar(); put_quarter();
        cancel = 1'b1; tick();
        cancel = 1'b0;
        check("t5_busy", int'(busy), 1);
        tick();
        check("t5_chg_d", int'(chg_d), 1);
        check("t5_credit25", int'(credit), 25);
        chg_ready = 1'b0;
        quarter = 1'b1; tick();
        quarter = 1'b0;
        check("t5_gap", int'(chg_q | chg_d), 0);
        check("t5_coin_reject", int'(coin_reject), 1);
        check("t5_credit_hold", int'(credit), 25);
        chg_ready = 1'b1; tick();
        check("t5_chg_q", int'(chg_q), 1);
        check("t5_credit0", int'(credit), 0);
        tick();
        check("t5_idle", int'(busy), 0);

        // 6: simultaneous coins, credit ceiling, then reset mid-DISPENSE
        dollar = 1'b1; quarter = 1'b1; tick();
        dollar = 1'b0; quarter = 1'b0;
        check("t6_dual_credit", int'(credit), 100);
        check("t6_dual_reject", int'(coin_reject), 1);
        tick();
        for (int i = 0; i < 8; i++) put_dollar();
        for (int i = 0; i < 3; i++) put_quarter();
        check("t6_credit975", int'(credit), 975);
        dollar = 1'b1; tick();
        dollar = 1'b0;
        check("t6_max_reject", int'(coin_reject), 1);
        check("t6_max_credit", int'(credit), 975);
        tick();
        select = 4'b1000;
        buy = 1'b1; tick(); tick();
        check("t6_disp_req", int'(disp_req), 1);
        tick();
        reset_n = 1'b0;
        #1;
        check("t6_async_req", int'(disp_req), 0);
        check("t6_async_credit", int'(credit), 0);
        check("t6_async_busy", int'(busy), 0);
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        check("t6_no_check_busy", int'(busy), 0);
        check("t6_no_check_req", int'(disp_req), 0);
        check("t6_no_check_err", int'(err_valid), 0);
        buy = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
